// File: rtl/switch_event_encoder_if.sv
// Event handshake bundle between switch_event_encoder (master) and the game FSM (slave).
interface switch_event_encoder_if #(
  parameter int unsigned N_SW = 4
);
  localparam int unsigned IDX_W = (N_SW > 1) ? $clog2(N_SW) : 1;

  logic             EVT_VALID;
  logic             EVT_READY;
  logic [IDX_W-1:0] EVT_INDEX;
  logic             EVT_LEVEL;

  modport master (output EVT_VALID, output EVT_INDEX, output EVT_LEVEL, input EVT_READY);
  modport slave  (input EVT_VALID, input EVT_INDEX, input EVT_LEVEL, output EVT_READY);
endinterface

// File: rtl/switch_event_encoder.sv
// Synchronises, debounces and queues slide-switch changes as {index, level} events.
// Define SWITCH_EVT_FALL_EN to also report falling changes; otherwise only rising ones.
module switch_event_encoder #(
  parameter int unsigned N_SW            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1250000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic [N_SW-1:0]        SWITCHES,
  switch_event_encoder_if.master evt,
  output logic [N_SW-1:0]        SW_STABLE,
  output logic                   EVT_OVERFLOW
);
  localparam int unsigned IDX_W = (N_SW > 1) ? $clog2(N_SW) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef SWITCH_EVT_FALL_EN
  localparam int unsigned ENT_W = IDX_W + 1;
`else
  localparam int unsigned ENT_W = IDX_W;
`endif

  logic [N_SW-1:0]  r_meta;
  logic [N_SW-1:0]  r_sync;
  logic [N_SW-1:0]  r_stable;
  logic [N_SW-1:0]  r_pend;
  logic [CNT_W-1:0] r_cnt [N_SW];
  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_wptr_vis;
  logic [PTR_W-1:0] r_rptr;
  logic             r_ovf;
`ifdef SWITCH_EVT_FALL_EN
  logic [N_SW-1:0]  r_pend_lvl;
`endif

  logic [N_SW-1:0]  w_accept;
  logic [N_SW-1:0]  w_evt;
  logic [N_SW-1:0]  w_clr;
  logic [N_SW-1:0]  w_pend_nxt;
  logic             w_lost;
  logic             w_sel_vld;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic [ENT_W-1:0] w_push_ent;
  logic [ENT_W-1:0] w_head;

  always_comb begin
    w_accept = '0;
    for (int unsigned i = 0; i < N_SW; i++)
      w_accept[i] = (r_sync[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
  end

`ifdef SWITCH_EVT_FALL_EN
  assign w_evt = w_accept;
`else
  assign w_evt = w_accept & r_sync;
`endif

  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_idx = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      if (r_pend[i] && !w_sel_vld) begin
        w_sel_vld = 1'b1;
        w_sel_idx = IDX_W'(i);
      end
    end
  end

  // Entries become visible one cycle after their write, so empty uses a lagged write pointer
  assign w_empty = (r_wptr_vis == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = !w_empty && evt.EVT_READY;
  assign w_push  = w_sel_vld && (!w_full || w_pop);

  always_comb begin
    w_clr = '0;
    if (w_push)
      w_clr[w_sel_idx] = 1'b1;
  end

  // A new accept overwrites a pending event only if that event is not leaving this cycle
  assign w_pend_nxt = (r_pend & ~w_clr) | w_evt;
  assign w_lost     = |(r_pend & ~w_clr & w_evt);

`ifdef SWITCH_EVT_FALL_EN
  assign w_push_ent = {w_sel_idx, r_pend_lvl[w_sel_idx]};
`else
  assign w_push_ent = w_sel_idx;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_stable   <= '0;
      r_pend     <= '0;
      r_wptr     <= '0;
      r_wptr_vis <= '0;
      r_rptr     <= '0;
      r_ovf      <= 1'b0;
      for (int unsigned i = 0; i < N_SW; i++)
        r_cnt[i] <= '0;
    end else begin
      r_meta <= SWITCHES;
      r_sync <= r_meta;
      for (int unsigned i = 0; i < N_SW; i++) begin
        if (r_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= r_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
      r_pend <= w_pend_nxt;
      if (w_lost)
        r_ovf <= 1'b1;
      if (w_push)
        r_wptr <= r_wptr + PTR_W'(1);
      r_wptr_vis <= r_wptr;
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
    end
  end

`ifdef SWITCH_EVT_FALL_EN
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_pend_lvl <= '0;
    end else begin
      for (int unsigned i = 0; i < N_SW; i++)
        if (w_evt[i])
          r_pend_lvl[i] <= r_sync[i];
    end
  end
`endif

  always_ff @(posedge CLOCK) begin
    if (w_push)
      r_mem[r_wptr[AW-1:0]] <= w_push_ent;
  end

  assign w_head        = r_mem[r_rptr[AW-1:0]];
  assign evt.EVT_VALID = !w_empty;
  assign evt.EVT_INDEX = w_empty ? '0 : w_head[ENT_W-1 -: IDX_W];
`ifdef SWITCH_EVT_FALL_EN
  assign evt.EVT_LEVEL = w_empty ? 1'b0 : w_head[0];
`else
  assign evt.EVT_LEVEL = 1'b1;
`endif
  assign SW_STABLE    = r_stable;
  assign EVT_OVERFLOW = r_ovf;

endmodule

// File: tb/tb_switch_event_encoder.sv
// Directed bench for switch_event_encoder with a cycle-level event-queue model.
module tb_switch_event_encoder;
  localparam int N     = 4;
  localparam int D     = 4;
  localparam int DEPTH = 4;
`ifdef SWITCH_EVT_FALL_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  logic         CLOCK = 1'b0;
  logic         RESET = 1'b1;
  logic [N-1:0] SWITCHES = '0;
  logic [N-1:0] SW_STABLE;
  logic         EVT_OVERFLOW;

  switch_event_encoder_if #(.N_SW(N)) bus ();

  switch_event_encoder #(.N_SW(N), .DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .SWITCHES    (SWITCHES),
    .evt         (bus),
    .SW_STABLE   (SW_STABLE),
    .EVT_OVERFLOW(EVT_OVERFLOW)
  );

  always #5 CLOCK = ~CLOCK;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: each switch accepts a level held for D consecutive synchronised cycles;
  // accepted events wait in pend[], then move lowest-first into a timestamped queue.
  typedef struct {int idx; int lvl; int t;} ent_t;
  ent_t q[$];
  ent_t e;
  int   edge_n = 0;
  bit   m_s1[N], m_s2[N], m_st[N], m_pend[N], m_plvl[N];
  int   m_run[N];
  bit   m_ovf;
  bit   m_pop, m_push;
  int   m_slots, m_sel;

  function automatic bit m_valid();
    return (q.size() > 0) && (q[0].t < edge_n);
  endfunction

  always @(posedge CLOCK) begin
    if (RESET) begin
      q.delete();
      m_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_pend[i] = 0; m_plvl[i] = 0; m_run[i] = 0;
      end
    end else begin
      m_pop   = m_valid() && bus.EVT_READY;
      m_slots = DEPTH - q.size() + (m_pop ? 1 : 0);
      m_sel   = -1;
      for (int i = 0; i < N; i++) if (m_pend[i] && m_sel < 0) m_sel = i;
      m_push = (m_sel >= 0) && (m_slots > 0);
      if (m_push) begin
        e.idx = m_sel; e.lvl = m_plvl[m_sel]; e.t = edge_n + 1;
        m_pend[m_sel] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_st[i]  = m_s2[i];
            m_run[i] = 0;
            if (FALL_EN || m_s2[i]) begin
              if (m_pend[i]) m_ovf = 1'b1;
              m_pend[i] = 1;
              m_plvl[i] = m_s2[i];
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      for (int i = 0; i < N; i++) begin
        m_s2[i] = m_s1[i];
        m_s1[i] = SWITCHES[i];
      end
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(e);
    end
    edge_n++;
  end

  always @(negedge CLOCK) begin
    if (cmp_en) begin
      int st;
      st = 0;
      for (int i = 0; i < N; i++) st |= int'(m_st[i]) << i;
      chk("m_valid", int'(bus.EVT_VALID), int'(m_valid()));
      chk("m_stable", int'(SW_STABLE), st);
      chk("m_overflow", int'(EVT_OVERFLOW), int'(m_ovf));
      if (m_valid()) begin
        chk("m_index", int'(bus.EVT_INDEX), q[0].idx);
        chk("m_level", int'(bus.EVT_LEVEL), FALL_EN ? q[0].lvl : 1);
      end else if (!FALL_EN) begin
        chk("m_level_tied", int'(bus.EVT_LEVEL), 1);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  initial begin
    int cnt;
    bus.EVT_READY = 1'b0;
    wait_cyc(1);
    cmp_en = 1'b1;
    wait_cyc(2);
    RESET = 1'b0;
    chk("rst_valid", int'(bus.EVT_VALID), 0);
    chk("rst_index", int'(bus.EVT_INDEX), 0);
    chk("rst_level", int'(bus.EVT_LEVEL), FALL_EN ? 0 : 1);
    chk("rst_stable", int'(SW_STABLE), 0);
    chk("rst_overflow", int'(EVT_OVERFLOW), 0);

    // Single rising switch: latency pinned at cycles 5/6/7/8
    SWITCHES = 4'b0100;
    wait_cyc(5); chk("lat_stable5", int'(SW_STABLE), 4'b0000);
    wait_cyc(1); chk("lat_stable6", int'(SW_STABLE), 4'b0100);
    wait_cyc(1); chk("lat_valid7", int'(bus.EVT_VALID), 0);
    wait_cyc(1); chk("lat_valid8", int'(bus.EVT_VALID), 1);
    chk("lat_index8", int'(bus.EVT_INDEX), 2);
    chk("lat_level8", int'(bus.EVT_LEVEL), 1);
    bus.EVT_READY = 1'b1;
    wait_cyc(1); bus.EVT_READY = 1'b0;
    chk("pop_empty", int'(bus.EVT_VALID), 0);

    // Glitch of D-1 cycles, then a hold of exactly D cycles
    SWITCHES = 4'b0101; wait_cyc(3);
    SWITCHES = 4'b0100; wait_cyc(8);
    chk("glitch_stable", int'(SW_STABLE), 4'b0100);
    chk("glitch_valid", int'(bus.EVT_VALID), 0);
    SWITCHES = 4'b0101; wait_cyc(4);
    SWITCHES = 4'b0100; wait_cyc(4);
    chk("hold_valid", int'(bus.EVT_VALID), 1);
    chk("hold_index", int'(bus.EVT_INDEX), 0);
    chk("hold_level", int'(bus.EVT_LEVEL), 1);
    bus.EVT_READY = 1'b1;
    wait_cyc(20);
    chk("drain_valid", int'(bus.EVT_VALID), 0);

    // Simultaneous changes drain lowest index first on consecutive cycles
    SWITCHES = 4'b0000; wait_cyc(10);
    SWITCHES = 4'b1011; wait_cyc(8);
    chk("multi_v0", int'(bus.EVT_VALID), 1);
    chk("multi_i0", int'(bus.EVT_INDEX), 0);
    wait_cyc(1); chk("multi_i1", int'(bus.EVT_INDEX), 1);
    wait_cyc(1); chk("multi_i3", int'(bus.EVT_INDEX), 3);
    wait_cyc(1); chk("multi_empty", int'(bus.EVT_VALID), 0);

    // Fill the FIFO, then force a pending loss on switch 0
    SWITCHES = 4'b0000; RESET = 1'b1; wait_cyc(2);
    RESET = 1'b0; bus.EVT_READY = 1'b0; wait_cyc(2);
    SWITCHES = 4'b1111; wait_cyc(12);
    chk("full_valid", int'(bus.EVT_VALID), 1);
    chk("full_index", int'(bus.EVT_INDEX), 0);
    chk("full_ovf0", int'(EVT_OVERFLOW), 0);
    SWITCHES = 4'b1110; wait_cyc(8);
    SWITCHES = 4'b1111; wait_cyc(8);
    chk("ovf_first", int'(EVT_OVERFLOW), FALL_EN ? 1 : 0);
    SWITCHES = 4'b1110; wait_cyc(8);
    SWITCHES = 4'b1111; wait_cyc(8);
    chk("ovf_set", int'(EVT_OVERFLOW), 1);

    // Pop and push in one cycle while full keeps four entries
    bus.EVT_READY = 1'b1; wait_cyc(1); bus.EVT_READY = 1'b0;
    chk("pp_valid", int'(bus.EVT_VALID), 1);
    chk("pp_index", int'(bus.EVT_INDEX), 1);
    cnt = 0;
    bus.EVT_READY = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.EVT_VALID) cnt++;
      wait_cyc(1);
    end
    bus.EVT_READY = 1'b0;
    chk("pp_occupancy", cnt, 4);
    chk("ovf_sticky", int'(EVT_OVERFLOW), 1);

    // Reset mid-queue, with switches held high through it
    SWITCHES = 4'b0000; wait_cyc(12);
    SWITCHES = 4'b1111; wait_cyc(12);
    chk("mq_valid", int'(bus.EVT_VALID), 1);
    RESET = 1'b1; wait_cyc(1);
    chk("mq_rst_valid", int'(bus.EVT_VALID), 0);
    chk("mq_rst_ovf", int'(EVT_OVERFLOW), 0);
    chk("mq_rst_stable", int'(SW_STABLE), 0);
    RESET = 1'b0;
    wait_cyc(6); chk("held_stable", int'(SW_STABLE), 4'b1111);
    wait_cyc(2);
    chk("held_valid", int'(bus.EVT_VALID), 1);
    chk("held_index", int'(bus.EVT_INDEX), 0);

    // Falling change on switch 1
    bus.EVT_READY = 1'b1;
    SWITCHES = 4'b0010; wait_cyc(15);
    chk("fall_pre_stable", int'(SW_STABLE), 4'b0010);
    chk("fall_pre_valid", int'(bus.EVT_VALID), 0);
    bus.EVT_READY = 1'b0;
    SWITCHES = 4'b0000; wait_cyc(6);
    chk("fall_stable", int'(SW_STABLE), 4'b0000);
    wait_cyc(2);
    chk("fall_valid", int'(bus.EVT_VALID), FALL_EN ? 1 : 0);
`ifdef SWITCH_EVT_FALL_EN
    chk("fall_index", int'(bus.EVT_INDEX), 1);
    chk("fall_level", int'(bus.EVT_LEVEL), 0);
`else
    chk("fall_level_tied", int'(bus.EVT_LEVEL), 1);
`endif
    wait_cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
